cache_ctrl_fsm: RTL
===================

# cache_ctrl_fsm

Request-side controller for the 4-way set-associative cache. Accepts CPU lookup requests, registers tag/index into the tag memory block, consumes its four per-way hit lines, tracks per-set tree pseudo-LRU state, and on a miss runs a refill handshake to next-level memory. It then asserts exactly one tag write enable to install the tag in the victim way.

## Interface
- tagSize, 20, tag field width
- NoOfSets, 64, number of sets; equals 2**indexWidth
- indexWidth, 6, set index width
- offsetWidth, 2, line offset width; carried in the request address and ignored
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- reqValid  in  1  CPU request valid
- reqReady  out  1  controller can accept a request
- reqAddr  in  tagSize+indexWidth+offsetWidth  request byte address {tag,index,offset}
- respValid  out  1  one-cycle completion pulse
- respHit  out  1  qualifies respValid: 1 = hit, 0 = miss serviced by refill
- respWay  out  2  way that hit or was filled
- multiHit  out  1  one-cycle flag with respValid: more than one hitWay was high
- tag  out  tagSize  registered tag to the tag memory block
- index  out  indexWidth  registered index to the tag memory block
- hitWay0, hitWay1, hitWay2, hitWay3  in  1 each  per-way compare results from the tag memory block
- TWEnWay0, TWEnWay1, TWEnWay2, TWEnWay3  out  1 each  per-way tag write enables
- memReqValid  out  1  refill request valid
- memReqReady  in  1  memory accepts refill request
- memReqAddr  out  tagSize+indexWidth  line address {tag,index}
- memRespValid  in  1  refill data returned
- hitCount, missCount  out  32 each  performance counters (see Configuration)

## Operation
- States: IDLE, LOOKUP, MISS_REQ, MISS_WAIT, FILL.
- IDLE: reqReady=1. On reqValid&reqReady, register tag/index from reqAddr and go to LOOKUP. Otherwise stay.
- LOOKUP: sample hitWay0..3.
  - Any hit: respValid=1, respHit=1, respWay=lowest-numbered hitting way, multiHit=1 if two or more hits. Update the set's PLRU for respWay, then go to IDLE.
  - No hit: latch the victim from PLRU and go to MISS_REQ.
- MISS_REQ: memReqValid=1, memReqAddr={tag,index}, both stable until memReqReady. On handshake go to MISS_WAIT.
- MISS_WAIT: wait for memRespValid, which is ignored in all other states. Then go to FILL.
- FILL: exactly one TWEnWay high (the victim) for one cycle. respValid=1, respHit=0, respWay=victim. PLRU update marks the victim MRU. Go to IDLE.
- tag/index hold their value from acceptance until the next acceptance.
- PLRU: 3 bits {b2,b1,b0} per set, NoOfSets entries.
  - Victim selection: b0=0 → (b1=0 ? way0 : way1); b0=1 → (b2=0 ? way2 : way3).
  - Update on access of way 0/1/2/3: way0 sets b0=1,b1=1; way1 sets b0=1,b1=0; way2 sets b0=0,b2=1; way3 sets b0=0,b2=0. Bits not named are unchanged.
- Reset (async, low), any state:
  - State → IDLE; all PLRU bits = 0 (victim way0).
  - tag=0, index=0.
  - reqReady=1 (IDLE). respValid, respHit, respWay, multiHit, memReqValid, TWEnWay0..3 = 0. memReqAddr=0. Counters = 0.
  - An in-flight refill is abandoned. Memory-side cleanup is the system's responsibility.

## Timing
- Request accepted at edge N: LOOKUP in cycle N+1. A hit completes with respValid in cycle N+1; the next request can be accepted at edge N+2.
- Miss: memReqValid first high in cycle N+2.
- memReqReady at edge M: MISS_WAIT from cycle M+1. memRespValid at edge K (K≥M+1): FILL in cycle K+1 with TWEn and respValid.
- Minimum miss turnaround, acceptance to respValid: 4 cycles.
- reqReady is 0 in every state except IDLE. No request is queued.
- The tag memory compare must be combinational from registered tag/index, valid within the LOOKUP cycle.

## Configuration
- CACHE_CTRL_PERF_CNT_EN defined:
  - hitCount increments on every LOOKUP hit.
  - missCount increments on every LOOKUP→MISS_REQ transition.
  - Both saturate at 32'hFFFFFFFF and are cleared by reset.
- Not defined: hitCount and missCount are tied to 0 and no counter flops exist.

## Test plan
- Reset, then request addr tag=0x12345, index=3 with hitWay2=1 in LOOKUP → respValid=1, respHit=1, respWay=2 one cycle after acceptance. Set 3 PLRU becomes b0=0,b2=1.
- Reset, then miss on index=5 (all hits 0) → memReqAddr={tag,5}. Hold memReqReady=0 for 3 cycles: memReqValid and memReqAddr stay stable. Then memReqReady=1, memRespValid 2 cycles later → TWEnWay0 pulses one cycle, respHit=0, respWay=0.
- Four consecutive misses to index 7 → victims way0, way2, way1, way3 in that order. Exactly one TWEn per fill.
- hitWay1=hitWay3=1 in LOOKUP → respWay=1, multiHit=1 for one cycle.
- Assert reset during MISS_WAIT → memReqValid and all TWEn low immediately, reqReady=1. A subsequent memRespValid causes no TWEn.
- With CACHE_CTRL_PERF_CNT_EN: 3 hits and 2 misses → hitCount=3, missCount=2. Without the macro, both read 0.

Source files
------------

// File: rtl/cache_ctrl_fsm_if.sv
// cache_ctrl_fsm_if: signal bundle between the cache request controller and its
// environment (CPU request/response, tag memory compare/write, refill memory side,
// performance counters).
//   master modport: the controller (cache_ctrl_fsm)
//   slave modport : CPU, tag memory and next-level memory taken together
interface cache_ctrl_fsm_if #(
  parameter int unsigned tagSize     = 20,
  parameter int unsigned indexWidth  = 6,
  parameter int unsigned offsetWidth = 2
);
  // CPU request / response
  logic                                      reqValid;
  logic                                      reqReady;
  logic [tagSize+indexWidth+offsetWidth-1:0] reqAddr;
  logic                                      respValid;
  logic                                      respHit;
  logic [1:0]                                respWay;
  logic                                      multiHit;
  // Tag memory side
  logic [tagSize-1:0]                        tag;
  logic [indexWidth-1:0]                     index;
  logic                                      hitWay0;
  logic                                      hitWay1;
  logic                                      hitWay2;
  logic                                      hitWay3;
  logic                                      TWEnWay0;
  logic                                      TWEnWay1;
  logic                                      TWEnWay2;
  logic                                      TWEnWay3;
  // Refill memory side
  logic                                      memReqValid;
  logic                                      memReqReady;
  logic [tagSize+indexWidth-1:0]             memReqAddr;
  logic                                      memRespValid;
  // Performance counters
  logic [31:0]                               hitCount;
  logic [31:0]                               missCount;

  modport master (
    input  reqValid, reqAddr, hitWay0, hitWay1, hitWay2, hitWay3, memReqReady, memRespValid,
    output reqReady, respValid, respHit, respWay, multiHit, tag, index,
           TWEnWay0, TWEnWay1, TWEnWay2, TWEnWay3, memReqValid, memReqAddr,
           hitCount, missCount
  );

  modport slave (
    output reqValid, reqAddr, hitWay0, hitWay1, hitWay2, hitWay3, memReqReady, memRespValid,
    input  reqReady, respValid, respHit, respWay, multiHit, tag, index,
           TWEnWay0, TWEnWay1, TWEnWay2, TWEnWay3, memReqValid, memReqAddr,
           hitCount, missCount
  );
endinterface

// File: rtl/cache_ctrl_fsm.sv
// cache_ctrl_fsm: request-side controller for a 4-way set-associative cache.
// Registers tag/index of an accepted CPU request for the tag memory, resolves the
// four per-way hit lines, keeps a 3-bit tree pseudo-LRU per set and on a miss runs
// a refill handshake, then pulses one tag write enable for the victim way.
//
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous active-low reset
//   bus   - cache_ctrl_fsm_if.master (CPU req/resp, tag memory, refill memory, counters)
//
// Optional feature: define CACHE_CTRL_PERF_CNT_EN to build saturating hit/miss
// counters; otherwise hitCount/missCount are tied to zero.
module cache_ctrl_fsm #(
  parameter int unsigned tagSize     = 20,
  parameter int unsigned NoOfSets    = 64,
  parameter int unsigned indexWidth  = 6,
  parameter int unsigned offsetWidth = 2
) (
  input logic            clk,
  input logic            reset,
  cache_ctrl_fsm_if.master bus
);

  typedef enum logic [2:0] {StIdle, StLookup, StMissReq, StMissWait, StFill} state_e;

  state_e                state_q, state_d;
  logic [tagSize-1:0]    tag_q, tag_d;
  logic [indexWidth-1:0] index_q, index_d;
  logic [1:0]            victim_q, victim_d;
  logic [2:0]            plru_q [NoOfSets];  // {b2,b1,b0}

  logic                  plru_we;
  logic [1:0]            plru_way;
  logic [3:0]            hits;
  logic                  any_hit;
  logic                  multi_hit;
  logic [1:0]            hit_way;
  logic                  unused_offset;

  // Offset bits are line-internal and play no part in lookup.
  assign unused_offset = ^bus.reqAddr[offsetWidth-1:0];

  assign hits      = {bus.hitWay3, bus.hitWay2, bus.hitWay1, bus.hitWay0};
  assign any_hit   = |hits;
  // More than one bit set: clearing the lowest set bit leaves something.
  assign multi_hit = (hits & (hits - 4'd1)) != 4'd0;

  always_comb begin
    hit_way = 2'd0;
    if (hits[0])      hit_way = 2'd0;
    else if (hits[1]) hit_way = 2'd1;
    else if (hits[2]) hit_way = 2'd2;
    else if (hits[3]) hit_way = 2'd3;
  end

  function automatic logic [1:0] plru_victim(input logic [2:0] b);
    if (!b[0]) return b[1] ? 2'd1 : 2'd0;
    else       return b[2] ? 2'd3 : 2'd2;
  endfunction

  function automatic logic [2:0] plru_touch(input logic [2:0] b, input logic [1:0] way);
    logic [2:0] r;
    r = b;
    unique case (way)
      2'd0: begin r[0] = 1'b1; r[1] = 1'b1; end
      2'd1: begin r[0] = 1'b1; r[1] = 1'b0; end
      2'd2: begin r[0] = 1'b0; r[2] = 1'b1; end
      2'd3: begin r[0] = 1'b0; r[2] = 1'b0; end
      default: r = b;
    endcase
    return r;
  endfunction

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      tag_q    <= '0;
      index_q  <= '0;
      victim_q <= '0;
      for (int i = 0; i < int'(NoOfSets); i++) plru_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      index_q  <= index_d;
      victim_q <= victim_d;
      if (plru_we) plru_q[index_q] <= plru_touch(plru_q[index_q], plru_way);
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    tag_d    = tag_q;
    index_d  = index_q;
    victim_d = victim_q;
    plru_we  = 1'b0;
    plru_way = hit_way;
    unique case (state_q)
      StIdle: begin
        if (bus.reqValid) begin
          tag_d   = bus.reqAddr[tagSize+indexWidth+offsetWidth-1 -: tagSize];
          index_d = bus.reqAddr[offsetWidth +: indexWidth];
          state_d = StLookup;
        end
      end
      StLookup: begin
        if (any_hit) begin
          plru_we = 1'b1;
          state_d = StIdle;
        end else begin
          victim_d = plru_victim(plru_q[index_q]);
          state_d  = StMissReq;
        end
      end
      StMissReq: begin
        if (bus.memReqReady) state_d = StMissWait;
      end
      StMissWait: begin
        if (bus.memRespValid) state_d = StFill;
      end
      StFill: begin
        plru_we  = 1'b1;
        plru_way = victim_q;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from current state (and hit lines during lookup)
  always_comb begin
    bus.reqReady    = 1'b0;
    bus.respValid   = 1'b0;
    bus.respHit     = 1'b0;
    bus.respWay     = 2'd0;
    bus.multiHit    = 1'b0;
    bus.memReqValid = 1'b0;
    bus.TWEnWay0    = 1'b0;
    bus.TWEnWay1    = 1'b0;
    bus.TWEnWay2    = 1'b0;
    bus.TWEnWay3    = 1'b0;
    unique case (state_q)
      StIdle:    bus.reqReady = 1'b1;
      StLookup: begin
        bus.respValid = any_hit;
        bus.respHit   = any_hit;
        bus.respWay   = any_hit ? hit_way : 2'd0;
        bus.multiHit  = multi_hit;
      end
      StMissReq: bus.memReqValid = 1'b1;
      StMissWait: ;
      StFill: begin
        bus.respValid = 1'b1;
        bus.respWay   = victim_q;
        unique case (victim_q)
          2'd0: bus.TWEnWay0 = 1'b1;
          2'd1: bus.TWEnWay1 = 1'b1;
          2'd2: bus.TWEnWay2 = 1'b1;
          2'd3: bus.TWEnWay3 = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign bus.tag        = tag_q;
  assign bus.index      = index_q;
  // tag/index only change on acceptance, so the line address is stable while requesting.
  assign bus.memReqAddr = {tag_q, index_q};

`ifdef CACHE_CTRL_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == StLookup) begin
      if (any_hit) begin
        if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
      end else begin
        if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign bus.hitCount  = hit_cnt_q;
  assign bus.missCount = miss_cnt_q;
`else
  assign bus.hitCount  = 32'd0;
  assign bus.missCount = 32'd0;
`endif

endmodule
